// File: rtl/smag_mac_if.sv
// smag_mac_if: sample inputs and product/accumulator outputs of smag_mac
interface smag_mac_if #(
    parameter int MAG_W = 2,
    parameter int ACC_W = 16,
    parameter int CNT_W = 12
);
    logic               in_valid;
    logic [MAG_W:0]     carrier;
    logic [MAG_W:0]     signal;
    logic               dump;
    logic [2*MAG_W:0]   prod;
    logic               prod_valid;
    logic [ACC_W-1:0]   acc_out;
    logic               acc_valid;
    logic [CNT_W-1:0]   acc_count;
    logic               overflow;
    modport master (
        output in_valid, carrier, signal, dump,
        input  prod, prod_valid, acc_out, acc_valid, acc_count, overflow
    );
    modport slave (
        input  in_valid, carrier, signal, dump,
        output prod, prod_valid, acc_out, acc_valid, acc_count, overflow
    );
endinterface

// File: rtl/smag_mac.sv
// smag_mac: sign-magnitude multiplier feeding a saturating integrate-and-dump accumulator
module smag_mac #(
    parameter int MAG_W = 2,
    parameter int ACC_W = 16,
    parameter int CNT_W = 12
) (
    input logic       clk,
    input logic       reset_n,
    smag_mac_if.slave bus
);
    typedef enum logic {IDLE, ACCUM} state_t;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [2*MAG_W:0]   prod_q, prod_d;
    logic               prod_valid_q, prod_valid_d, dump_q, dump_d;
    logic [2*MAG_W-1:0] mag;
    logic [ACC_W-1:0]   mag_ext, prod_tc, sat, acc_q, acc_d, acc_out_q, acc_out_d;
    logic [ACC_W:0]     sum;
    logic               clamp, fire, sticky_q, sticky_d, acc_valid_q, acc_valid_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cnt_inc, cnt_q, cnt_d, acc_count_q, acc_count_d;
    state_t             state_q, state_d;
    always_comb begin
        mag = {{MAG_W{1'b0}}, bus.carrier[MAG_W-1:0]} * {{MAG_W{1'b0}}, bus.signal[MAG_W-1:0]};
        prod_d = bus.in_valid ? {(bus.carrier[MAG_W] ^ bus.signal[MAG_W]) & (|mag), mag} : prod_q;
        prod_valid_d = bus.in_valid;
        dump_d = bus.in_valid & bus.dump;
    end
    // One extra sum bit exposes signed overflow as a mismatch of the top two bits
    always_comb begin
        mag_ext = {{(ACC_W-2*MAG_W){1'b0}}, prod_q[2*MAG_W-1:0]};
        prod_tc = prod_q[2*MAG_W] ? -mag_ext : mag_ext;
        sum = {acc_q[ACC_W-1], acc_q} + {prod_tc[ACC_W-1], prod_tc};
        clamp = sum[ACC_W] ^ sum[ACC_W-1];
        sat = clamp ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
        cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        fire = prod_valid_q & dump_q;
        acc_d = prod_valid_q ? (dump_q ? '0 : sat) : acc_q;
        cnt_d = prod_valid_q ? (dump_q ? '0 : cnt_inc) : cnt_q;
        sticky_d = prod_valid_q ? (~dump_q & (sticky_q | clamp)) : sticky_q;
        acc_valid_d = fire;
        acc_out_d = fire ? sat : acc_out_q;
        acc_count_d = fire ? cnt_inc : acc_count_q;
        overflow_d = fire ? (sticky_q | clamp) : overflow_q;
        state_d = prod_valid_q ? (dump_q ? IDLE : ACCUM) : state_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            dump_q       <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            acc_valid_q  <= 1'b0;
            acc_out_q    <= '0;
            acc_count_q  <= '0;
            overflow_q   <= 1'b0;
            state_q      <= IDLE;
        end else begin
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            dump_q       <= dump_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sticky_q     <= sticky_d;
            acc_valid_q  <= acc_valid_d;
            acc_out_q    <= acc_out_d;
            acc_count_q  <= acc_count_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
        end
    end
    assign bus.prod       = prod_q;
    assign bus.prod_valid = prod_valid_q;
    assign bus.acc_out    = acc_out_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_count  = acc_count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_smag_mac.sv
// tb_smag_mac: table vectors, directed corner sequences and random traffic against an integer model
module tb_smag_mac;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    smag_mac_if #(.MAG_W(2), .ACC_W(8), .CNT_W(4)) bus ();
    smag_mac #(.MAG_W(2), .ACC_W(8), .CNT_W(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0] c;
        logic [2:0] s;
        logic [4:0] p;
    } vec_t;
    vec_t tbl[7];
    int m_acc, m_cnt;
    bit m_flag;
    bit pend_fire;
    int pend_out, pend_cnt;
    bit pend_ovf;
    logic [4:0] e_prod;
    bit e_pv, e_av, e_ovf;
    logic [7:0] e_out;
    int e_cnt;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int smval(input logic [2:0] x);
        return x[2] ? -int'(x[1:0]) : int'(x[1:0]);
    endfunction
    task automatic model_clear();
        m_acc = 0; m_cnt = 0; m_flag = 0; pend_fire = 0;
        pend_out = 0; pend_cnt = 0; pend_ovf = 0;
        e_prod = '0; e_pv = 0; e_av = 0; e_ovf = 0; e_out = '0; e_cnt = 0;
    endtask
    task automatic check_all();
        chk("prod", int'(bus.prod), int'(e_prod));
        chk("prod_valid", int'(bus.prod_valid), int'(e_pv));
        chk("acc_valid", int'(bus.acc_valid), int'(e_av));
        chk("acc_out", int'(bus.acc_out), int'(e_out));
        chk("acc_count", int'(bus.acc_count), e_cnt);
        chk("overflow", int'(bus.overflow), int'(e_ovf));
    endtask
    task automatic step(input bit v, input logic [2:0] c, input logic [2:0] s, input bit d);
        int p, raw;
        bit clamped;
        bus.in_valid = v; bus.carrier = c; bus.signal = s; bus.dump = d;
        @(posedge clk);
        #1;
        e_av = pend_fire;
        if (pend_fire) begin
            e_out = pend_out[7:0]; e_cnt = pend_cnt; e_ovf = pend_ovf;
        end
        pend_fire = 0;
        e_pv = v;
        if (v) begin
            p = smval(c) * smval(s);
            e_prod = {p < 0, 4'(p < 0 ? -p : p)};
            raw = m_acc + p;
            clamped = raw > 127 || raw < -128;
            m_acc = raw > 127 ? 127 : (raw < -128 ? -128 : raw);
            m_flag = m_flag | clamped;
            m_cnt = m_cnt < 15 ? m_cnt + 1 : 15;
            if (d) begin
                pend_fire = 1; pend_out = m_acc; pend_cnt = m_cnt; pend_ovf = m_flag;
                m_acc = 0; m_cnt = 0; m_flag = 0;
            end
        end
        check_all();
    endtask
    task automatic expect_acc(input string name, input logic [7:0] o, input int cnt, input bit ovf);
        chk({name, "_valid"}, int'(bus.acc_valid), 1);
        chk({name, "_out"}, int'(bus.acc_out), int'(o));
        chk({name, "_count"}, int'(bus.acc_count), cnt);
        chk({name, "_ovf"}, int'(bus.overflow), int'(ovf));
    endtask
    task automatic check_zero(input string name);
        chk({name, "_prod"}, int'(bus.prod), 0);
        chk({name, "_pv"}, int'(bus.prod_valid), 0);
        chk({name, "_av"}, int'(bus.acc_valid), 0);
        chk({name, "_out"}, int'(bus.acc_out), 0);
        chk({name, "_cnt"}, int'(bus.acc_count), 0);
        chk({name, "_ovf"}, int'(bus.overflow), 0);
    endtask
    localparam logic [2:0] P3 = 3'b011, N3 = 3'b111, P1 = 3'b001, P2 = 3'b010, N2 = 3'b110;
    initial begin
        tbl[0] = '{3'b011, 3'b111, 5'b11001};
        tbl[1] = '{3'b100, 3'b111, 5'b00000};
        tbl[2] = '{3'b011, 3'b011, 5'b01001};
        tbl[3] = '{3'b101, 3'b010, 5'b10010};
        tbl[4] = '{3'b111, 3'b111, 5'b01001};
        tbl[5] = '{3'b000, 3'b110, 5'b00000};
        tbl[6] = '{3'b110, 3'b001, 5'b10010};
        bus.in_valid = 0; bus.carrier = '0; bus.signal = '0; bus.dump = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1, tbl[i].c, tbl[i].s, 1);
            chk("tbl_prod", int'(bus.prod), int'(tbl[i].p));
            chk("tbl_pv", int'(bus.prod_valid), 1);
        end
        step(0, '0, '0, 0);
        step(0, '0, '0, 0);
        step(1, P3, P3, 0); step(0, '0, '0, 1);
        step(1, P3, P3, 0); step(0, '0, '0, 0);
        step(1, P3, P3, 0); step(0, '0, '0, 0);
        step(1, P3, P3, 1);
        chk("gap_early", int'(bus.acc_valid), 0);
        step(0, '0, '0, 0);
        expect_acc("gap", 8'd36, 4, 0);
        step(0, '0, '0, 0);
        chk("gap_pulse_end", int'(bus.acc_valid), 0);
        chk("gap_hold", int'(bus.acc_out), 36);
        repeat (14) step(1, P3, P3, 0);
        step(1, P3, P3, 1);
        step(1, P3, N3, 1);
        expect_acc("sat", 8'd127, 15, 1);
        step(0, '0, '0, 0);
        expect_acc("neg", 8'hF7, 1, 0);
        step(1, P1, P1, 1);
        step(1, 3'b101, P2, 1);
        expect_acc("b2b1", 8'd1, 1, 0);
        step(1, P3, P1, 1);
        expect_acc("b2b2", 8'hFE, 1, 0);
        step(0, '0, '0, 0);
        expect_acc("b2b3", 8'd3, 1, 0);
        repeat (3) step(1, P3, P3, 0);
        bus.in_valid = 0;
        reset_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk);
        #1 check_zero("midrst_hold");
        @(negedge clk) reset_n = 1'b1;
        model_clear();
        step(1, P2, P2, 1);
        step(0, '0, '0, 0);
        expect_acc("postrst", 8'd4, 1, 0);
        step(0, N2, N2, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
                 i < 300 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 39) == 0);
        end
        step(0, '0, '0, 0);
        step(0, '0, '0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
